// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches on a req/addr_ok/data_ok
// SRAM-like bus, buffers responses in order and offers them to ID.
// Optional feature: define IF_ADEF_EN to turn a misaligned fetch PC into a
// synthetic faulting entry (if_id_adef) instead of a bus request.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int unsigned IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        id_allowin,
  output logic        if_id_valid,
  output logic [63:0] if_id_bus,
  output logic        if_id_adef,
  input  logic [32:0] br_bus
);

  localparam int unsigned PW = $clog2(IBUF_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]           fpc;
  logic [31:0]           ent_pc   [IBUF_DEPTH];
  logic [31:0]           ent_inst [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] ent_filled;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         fill_ptr;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         pend;
  logic [CW-1:0]         cancel_cnt;
`ifdef IF_ADEF_EN
  logic [IBUF_DEPTH-1:0] ent_adef;
  logic                  halted;
  logic                  misaligned;
  logic                  adef_alloc;
`endif

  logic        br_taken;
  logic [31:0] br_target;
  logic        can_fetch;
  logic        addr_hs;
  logic        alloc;
  logic        fill_en;
  logic        drop;
  logic        pop;
  logic [CW-1:0] pend_left;
  logic [CW-1:0] cancel_left;

  assign {br_taken, br_target} = br_bus;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fpc;

  // Fetch is possible with queue space, no stale responses pending and no redirect
`ifdef IF_ADEF_EN
  assign can_fetch  = !reset && (occ < CW'(IBUF_DEPTH)) && (cancel_cnt == '0) && !br_taken && !halted;
  assign misaligned = (fpc[1:0] != 2'b00);
  assign adef_alloc = can_fetch && misaligned;
  assign inst_sram_req = can_fetch && !misaligned;
  assign addr_hs    = inst_sram_req && inst_sram_addr_ok;
  assign alloc      = addr_hs || adef_alloc;
  assign if_id_adef = !reset && (occ != '0) && ent_adef[head];
`else
  assign can_fetch  = !reset && (occ < CW'(IBUF_DEPTH)) && (cancel_cnt == '0) && !br_taken;
  assign inst_sram_req = can_fetch;
  assign addr_hs    = inst_sram_req && inst_sram_addr_ok;
  assign alloc      = addr_hs;
  assign if_id_adef = 1'b0;
`endif

  // A response fills the oldest unfilled entry, which may be the one allocated this cycle
  assign fill_en = inst_sram_data_ok && (cancel_cnt == '0) && ((pend != '0) || addr_hs);
  assign drop    = inst_sram_data_ok && (cancel_cnt != '0);

  assign pend_left   = pend + CW'(addr_hs) - CW'(fill_en);
  assign cancel_left = cancel_cnt - CW'(drop);

  assign if_id_valid = !reset && (occ != '0) && ent_filled[head] && !br_taken;
  assign if_id_bus   = {ent_pc[head], ent_inst[head]};
  assign pop         = if_id_valid && id_allowin;

  // Queue state, fetch PC and stale-response bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc        <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      occ        <= '0;
      pend       <= '0;
      cancel_cnt <= '0;
      ent_filled <= '0;
`ifdef IF_ADEF_EN
      ent_adef   <= '0;
      halted     <= 1'b0;
`endif
    end else if (br_taken) begin
      // Requests still outstanding after this cycle return later and must be discarded;
      // stale responses not yet drained stay counted as well.
      fpc        <= br_target;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      occ        <= '0;
      pend       <= '0;
      cancel_cnt <= cancel_left + pend_left;
      ent_filled <= '0;
`ifdef IF_ADEF_EN
      ent_adef   <= '0;
      halted     <= 1'b0;
`endif
    end else begin
      if (addr_hs) begin
        fpc              <= fpc + 32'd4;
        ent_pc[tail]     <= fpc;
        ent_filled[tail] <= 1'b0;
`ifdef IF_ADEF_EN
        ent_adef[tail]   <= 1'b0;
`endif
      end
`ifdef IF_ADEF_EN
      if (adef_alloc) begin
        ent_pc[tail]     <= fpc;
        ent_inst[tail]   <= 32'h0;
        ent_filled[tail] <= 1'b1;
        ent_adef[tail]   <= 1'b1;
        halted           <= 1'b1;
      end
`endif
      if (alloc) begin
        tail <= tail + PW'(1);
      end
      if (fill_en) begin
        ent_inst[fill_ptr]   <= inst_sram_rdata;
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      occ        <= occ + CW'(alloc) - CW'(pop);
      pend       <= pend_left;
      cancel_cnt <= cancel_left;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        allowin = 1'b0;
  logic        valid, adef;
  logic [63:0] bus;
  logic [32:0] br_bus = 33'h0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(.RESET_PC(RPC), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata),
    .id_allowin(allowin), .if_id_valid(valid), .if_id_bus(bus), .if_id_adef(adef),
    .br_bus(br_bus)
  );

  typedef struct {
    logic        rst, aok, dok;
    logic [31:0] rd;
    logic        alw, br;
    logic [31:0] tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc, einst;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mfpc;
  int          mcancel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs mid-cycle; outputs settle 1ns later, next posedge commits
  task automatic apply(input logic rst, input logic aok, input logic dok, input logic [31:0] rd,
                       input logic alw, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    reset = rst; addr_ok = aok; data_ok = dok; rdata = rd;
    allowin = alw; br_bus = {br, tgt};
    #1;
  endtask

  task automatic add_vec(input logic rst, input logic aok, input logic dok, input logic [31:0] rd,
                         input logic alw, input logic br, input logic [31:0] tgt,
                         input logic ereq, input logic [31:0] eaddr, input logic evalid,
                         input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rst = rst; v.aok = aok; v.dok = dok; v.rd = rd; v.alw = alw; v.br = br; v.tgt = tgt;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.einst = einst;
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic ereq, input logic [31:0] eaddr,
                            input logic evalid, input logic [31:0] epc, input logic [31:0] einst);
    check({tag, ".req"}, 64'(req), 64'(ereq));
    if (ereq) check({tag, ".addr"}, 64'(addr), 64'(eaddr));
    check({tag, ".valid"}, 64'(valid), 64'(evalid));
    if (evalid) check({tag, ".bus"}, bus, {epc, einst});
    check({tag, ".adef"}, 64'(adef), 64'h0);
  endtask

  function automatic int unfilled_cnt();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  initial begin
    // ---- vector table ----
    add_vec(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h1c000000, 1'b0,32'h0,        32'h0);
    add_vec(1'b0,1'b1,1'b1,32'ha0000000, 1'b1,1'b0,32'h0,        1'b1,32'h1c000004, 1'b0,32'h0,        32'h0);
    add_vec(1'b0,1'b1,1'b1,32'ha0000001, 1'b1,1'b0,32'h0,        1'b1,32'h1c000008, 1'b1,32'h1c000000, 32'ha0000000);
    add_vec(1'b0,1'b1,1'b1,32'ha0000002, 1'b1,1'b0,32'h0,        1'b1,32'h1c00000c, 1'b1,32'h1c000004, 32'ha0000001);
    add_vec(1'b0,1'b1,1'b1,32'ha0000003, 1'b1,1'b0,32'h0,        1'b1,32'h1c000010, 1'b1,32'h1c000008, 32'ha0000002);
    add_vec(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h1c000014, 1'b1,32'h1c00000c, 32'ha0000003);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h1c000100, 1'b0,32'h0,        1'b0,32'h0,        32'h0);
    add_vec(1'b0,1'b0,1'b1,32'hdeadbeef, 1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h1c000100, 1'b0,32'h0,        32'h0);
    add_vec(1'b0,1'b0,1'b1,32'hb0000000, 1'b1,1'b0,32'h0,        1'b1,32'h1c000104, 1'b0,32'h0,        32'h0);
    add_vec(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h1c000104, 1'b1,32'h1c000100, 32'hb0000000);
    add_vec(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h1c000200, 1'b0,32'h0,        1'b0,32'h0,        32'h0);
    add_vec(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h1c000200, 1'b0,32'h0,        32'h0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].aok, tbl[i].dok, tbl[i].rd, tbl[i].alw, tbl[i].br, tbl[i].tgt);
      check_outs($sformatf("tbl%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].evalid, tbl[i].epc, tbl[i].einst);
    end

    // ---- full queue with ID stalled, then drain ----
    begin
      int hs_cnt = 0;
      apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 8; c++) begin
        apply(1'b0, 1'b1, (c >= 1 && c <= 4), 32'hc0 + 32'(c), 1'b0, 1'b0, 32'h0);
        if (req && addr_ok) hs_cnt++;
        if (c == 7) check("full.req", 64'(req), 64'h0);
      end
      check("full.hs_cnt", 64'(hs_cnt), 64'd4);
      for (int k = 0; k < 4; k++) begin
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check($sformatf("drain%0d.valid", k), 64'(valid), 64'h1);
        check($sformatf("drain%0d.bus", k), bus, {RPC + 32'(4 * k), 32'hc1 + 32'(k)});
        check($sformatf("drain%0d.req", k), 64'(req), (k == 0) ? 64'h0 : 64'h1);
      end
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check("drain.empty", 64'(valid), 64'h0);
    end

    // ---- redirect with three requests in flight ----
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check($sformatf("infl%0d.addr", k), 64'(addr), 64'(RPC + 32'(4 * k)));
    end
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c000100);
    check("br3.req", 64'(req), 64'h0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b1, 32'h5a5a0000 + 32'(k), 1'b1, 1'b0, 32'h0);
      check($sformatf("cancel%0d.req", k), 64'(req), 64'h0);
      check($sformatf("cancel%0d.valid", k), 64'(valid), 64'h0);
    end
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("br3.newreq", 64'(req), 64'h1);
    check("br3.newaddr", 64'(addr), 64'h1c000100);
    apply(1'b0, 1'b0, 1'b1, 32'he0e0e0e0, 1'b1, 1'b0, 32'h0);
    check("br3.notyet", 64'(valid), 64'h0);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("br3.valid", 64'(valid), 64'h1);
    check("br3.bus", bus, {32'h1c000100, 32'he0e0e0e0});

`ifdef IF_ADEF_EN
    // ---- misaligned redirect produces one faulting entry and halts fetch ----
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c000102);
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("adef.noreq0", 64'(req), 64'h0);
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("adef.noreq1", 64'(req), 64'h0);
    check("adef.valid", 64'(valid), 64'h1);
    check("adef.flag", 64'(adef), 64'h1);
    check("adef.bus", bus, {32'h1c000102, 32'h0});
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("adef.halt", 64'(req), 64'h0);
    check("adef.popped", 64'(valid), 64'h0);
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c000200);
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("adef.resume", 64'(req), 64'h1);
    check("adef.resaddr", 64'(addr), 64'h1c000200);
`endif

    // ---- randomized run against reference model ----
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    mq.delete(); mfpc = RPC; mcancel = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic rst, br, aok, dok, alw, ereq, evalid, hs;
      logic [31:0] tgt, rd;
      int outstanding;
      rst = ($urandom_range(0, 199) == 0);
      br  = !rst && ($urandom_range(0, 15) == 0);
      tgt = RPC + 32'($urandom_range(0, 255)) * 32'd4;
      aok = ($urandom_range(0, 3) != 0);
      alw = ($urandom_range(0, 2) != 0);
      rd  = $urandom;
      ereq = !rst && (mq.size() < DEPTH) && (mcancel == 0) && !br;
      hs   = ereq && aok;
      outstanding = mcancel + unfilled_cnt() + (hs ? 1 : 0);
      dok = !rst && (((outstanding > 0) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 63) == 0));
      evalid = !rst && (mq.size() > 0) && mq[0].filled && !br;

      apply(rst, aok, dok, rd, alw, br, tgt);
      check_outs($sformatf("rnd%0d", cyc), ereq, mfpc, evalid,
                 (mq.size() > 0) ? mq[0].pc : 32'h0, (mq.size() > 0) ? mq[0].inst : 32'h0);

      if (rst) begin
        mq.delete(); mfpc = RPC; mcancel = 0;
      end else begin
        if (hs) begin
          ment_t e;
          e.pc = mfpc; e.inst = 32'h0; e.filled = 1'b0;
          mq.push_back(e);
          mfpc = mfpc + 32'd4;
        end
        if (dok) begin
          if (mcancel > 0) mcancel--;
          else begin
            for (int i = 0; i < mq.size(); i++) begin
              if (!mq[i].filled) begin
                mq[i].filled = 1'b1;
                mq[i].inst = rd;
                break;
              end
            end
          end
        end
        if (evalid && alw) void'(mq.pop_front());
        if (br) begin
          mcancel += unfilled_cnt();
          mq.delete();
          mfpc = tgt;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000: first fetch address after reset.
REQ-002 SHALL have parameter IBUF_DEPTH, default 4: queue entries; power of 2, range 2..16.
REQ-003 SHALL have ports clk in 1, clock; reset in 1, synchronous active-high reset.
REQ-004 SHALL have inst_sram_req out 1, fetch request; inst_sram_wr out 1, tied 0; inst_sram_size out 2, tied 2'b10; inst_sram_wstrb out 4, tied 0; inst_sram_wdata out 32, tied 0.
REQ-005 SHALL have inst_sram_addr out 32, fetch PC; inst_sram_addr_ok in 1, request accepted; inst_sram_data_ok in 1, response valid; inst_sram_rdata in 32, response data.
REQ-006 SHALL have id_allowin in 1, ID can accept; if_id_valid out 1, head entry offered; if_id_bus out 64, {pc[63:32], inst[31:0]}; if_id_adef out 1, head entry carries fetch-address fault.
REQ-007 SHALL have br_bus in 33, {br_taken[32], br_target[31:0]}; br_taken is a one-cycle redirect pulse.

Function
REQ-008 SHALL hold fetch PC fpc; inst_sram_addr = fpc; fpc += 4 on every addr handshake (req & addr_ok).
REQ-009 SHALL keep an in-order queue of IBUF_DEPTH entries {pc, inst, filled, adef}; tail allocates on addr handshake with pc=fpc, filled=0.
REQ-010 SHALL fill the oldest unfilled entry on data_ok when cancel_cnt==0; inst <= rdata, filled <= 1, visible next cycle.
REQ-011 SHALL assert inst_sram_req only when: not reset, occupancy < IBUF_DEPTH, cancel_cnt==0, br_taken==0.
REQ-012 SHALL drive if_id_valid = head filled & occupancy!=0 & !br_taken; if_id_bus/if_id_adef from head entry.
REQ-013 SHALL pop head when if_id_valid & id_allowin; pop and allocate in same cycle SHALL both take effect, occupancy unchanged.
REQ-014 Latency: addr handshake cycle N, data_ok cycle M>=N -> earliest if_id_valid at M+1.
REQ-015 On br_taken: fpc <= br_target; all entries invalidated, occupancy <= 0; cancel_cnt <= number of allocated unfilled entries (excluding one filled by same-cycle data_ok).
REQ-016 On data_ok with cancel_cnt!=0: data discarded, cancel_cnt decremented; no entry written.
REQ-017 data_ok with cancel_cnt==0 and no unfilled entry is a protocol error: ignored, state unchanged.
REQ-018 cancel_cnt SHALL be clog2(IBUF_DEPTH)+1 bits and never exceed IBUF_DEPTH.
REQ-019 Queue full: req low; full with simultaneous pop SHALL NOT allow a same-cycle request (no bypass).
REQ-020 Pointer wrap: head/tail/fill pointers wrap modulo IBUF_DEPTH; empty/full distinguished by occupancy counter.

Reset
REQ-021 In reset: fpc <= RESET_PC, occupancy/pointers/cancel_cnt <= 0, all filled <= 0.
REQ-022 During reset: inst_sram_req=0, if_id_valid=0, if_id_adef=0; if_id_bus don't-care.
REQ-023 First cycle after reset deasserts: req=1, addr=RESET_PC.
REQ-024 Reset mid-operation SHALL drop all in-flight responses' bookkeeping; bench does not issue stale data_ok after reset.

Configuration
REQ-025 Macro IF_ADEF_EN defined: if fpc[1:0]!=0 and req conditions hold, no bus request; instead one entry allocated with filled=1, inst=0, adef=1, pc=fpc; fetch then halts until br_taken.
REQ-026 IF_ADEF_EN undefined: fpc[1:0] ignored for fault purposes, requests issued normally, if_id_adef tied 0, adef storage absent.

Verification
REQ-027 Reset release, addr_ok=1, data_ok one cycle later, id_allowin=1 -> if_id_bus pcs 0x1c000000, 0x1c000004, 0x1c000008 in consecutive cycles.
REQ-028 id_allowin=0, addr_ok=1, data_ok every cycle -> exactly 4 handshakes then req=0; release allowin -> 4 entries drained in order, req reasserts.
REQ-029 3 requests in flight (no data_ok), br_taken target 0x1c000100 -> cancel_cnt=3; next 3 data_ok discarded; next valid pc=0x1c000100.
REQ-030 br_taken while if_id_valid=1 -> if_id_valid=0 that cycle; head never accepted by ID.
REQ-031 IF_ADEF_EN defined, br_target 0x1c000102 -> no req, if_id_valid=1, if_id_adef=1, pc=0x1c000102, inst=0; req stays 0 until next br_taken.
